i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TGT_ADDR, default 7'h50, giving the 7-bit bus address this target answers.
REQ-002 SHALL have port `clk`, input, 1 bit: system clock, at least 8x the SCL frequency.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port `scl`, input, 1 bit: bus clock from the controller; the target never stretches SCL.
REQ-005 SHALL have port `sda`, inout, 1 bit: open-drain data; the target only drives 0 or Z.
REQ-006 SHALL have port `tx_data`, input, 8 bits: byte returned on a read; sampled at the start of each read byte.
REQ-007 SHALL have port `rx_data`, output, 8 bits: last byte written by the controller.
REQ-008 SHALL have port `rx_valid`, output, 1 bit: one-clk pulse when `rx_data` updates.
REQ-009 SHALL have port `tx_req`, output, 1 bit: one-clk pulse when `tx_data` is latched.
REQ-010 SHALL have port `busy`, output, 1 bit: high from an address match until STOP or return to IDLE.

Function
REQ-011 SHALL pass `scl` and `sda` through 2-flop synchronizers and detect edges on the synchronized copies only.
REQ-012 SHALL detect START as a synchronized `sda` 1->0 while `scl`=1, and STOP as `sda` 0->1 while `scl`=1.
REQ-013 SHALL use these FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP.
REQ-014 SHALL enter ADDR on START from any state; this covers repeated START.
REQ-015 SHALL return to IDLE on STOP from any state, release `sda`, and clear `busy`.
REQ-016 ADDR SHALL shift in 8 bits MSB-first, sampling on each `scl` rising edge; bits 7:1 are the address and bit 0 is R/W.
REQ-017 On address mismatch after the 8th bit, the FSM SHALL go to WAIT_STOP and never drive `sda`.
REQ-018 On address match, the FSM SHALL go to ADDR_ACK and pull `sda` low on the next `scl` falling edge.
REQ-019 ADDR_ACK SHALL hold `sda` low through the 9th clock high phase and set `busy` at the match.
REQ-020 Leaving ADDR_ACK on the 9th falling edge, the FSM SHALL release `sda` and go to WRITE if R/W=0.
REQ-021 Leaving ADDR_ACK with R/W=1, the FSM SHALL latch `tx_data`, pulse `tx_req`, drive bit 7, and go to READ.
REQ-022 WRITE SHALL shift 8 bits on rising edges; after the 8th bit it loads `rx_data`, pulses `rx_valid` for one clk, and enters WR_ACK.
REQ-023 WR_ACK SHALL pull `sda` low for one `scl` period, as in ADDR_ACK, then return to WRITE; writes are unlimited until STOP or START.
REQ-024 READ SHALL drive each bit on the `scl` falling edge, MSB first; a 1 bit releases `sda` (Z) and a 0 bit drives 0.
REQ-025 After the 8th falling edge of READ, the target SHALL release `sda`, enter RD_ACK, and sample the controller's ACK on the rising edge.
REQ-026 In RD_ACK, ACK (0) SHALL re-latch `tx_data`, pulse `tx_req`, and continue READ; NACK (1) SHALL go to WAIT_STOP.
REQ-027 The bit counter SHALL be 3 bits, wrapping 7->0 at each byte boundary, and SHALL be cleared by START.
REQ-028 `sda` output-enable SHALL be registered; it is never driven while `scl` is high except during an ACK or a held data bit.
REQ-029 A START or STOP arriving mid-byte SHALL abort the byte: no `rx_valid` pulse and `rx_data` unchanged.

Reset
REQ-030 While `rst`=1, the block SHALL asynchronously hold: state IDLE, `sda` released (Z), `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, counters 0, and synchronizers 1.
REQ-031 After `rst` deasserts, the block SHALL ignore bus activity until a valid START is seen; reset mid-transfer releases `sda` immediately.

Verification
REQ-032 Write 0xA0 then 0x3C, then STOP -> ACK after both bytes, `rx_data`=8'h3C, exactly one `rx_valid` pulse, `busy` falls after STOP.
REQ-033 Address 0x52 (write) -> no ACK (`sda` stays 1 on the 9th clock), `busy`=0, no `rx_valid`.
REQ-034 Address 0xA1 with `tx_data`=8'h96, controller ACK, then `tx_data`=8'h0F, controller NACK -> bus bytes 0x96 and 0x0F, two `tx_req` pulses, `sda` released after NACK.
REQ-035 Write 0xA0, 4 data bits, repeated START, then 0xA1 -> partial byte dropped, no `rx_valid`, address ACKed, READ entered.
REQ-036 `rst` asserted during a write ACK -> `sda` released the same cycle and all outputs at reset values; the next full write of 0x55 is received correctly.
REQ-037 STOP issued after 5 bits of a write -> state IDLE, `rx_data` unchanged, `busy`=0.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with a fixed 7-bit address.
//
// Ports:
//   clk      - system clock, at least 8x the SCL frequency
//   rst      - asynchronous active-high reset
//   scl      - bus clock from the controller (never stretched)
//   sda      - open-drain data line; this block drives only 0 or Z
//   tx_data  - byte returned on a read, latched at the start of each read byte
//   rx_data  - last complete byte written by the controller
//   rx_valid - one-clk pulse when rx_data updates
//   tx_req   - one-clk pulse when tx_data is latched
//   busy     - high from an address match until STOP / return to idle
module i2c_target #(
    parameter logic [6:0] TGT_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWrAck,
        StRead,
        StRdAck,
        StWaitStop
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       rw;
    logic       ack_hold;   // ack states: first falling edge seen; RD_ACK: controller acked
    logic       sda_oe;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shifted;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign shifted   = {shreg[6:0], sda_s};

    // Synchronizers reset to 1 so an idle bus produces no edges after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            rw       <= 1'b0;
            ack_hold <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (stop_det) begin
                state    <= StIdle;
                bit_cnt  <= 3'd0;
                ack_hold <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (start_det) begin
                // Also a repeated START: any partial byte is simply discarded.
                state    <= StAddr;
                bit_cnt  <= 3'd0;
                ack_hold <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (state)
                    StAddr: begin
                        if (scl_rise) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shreg[6:0] == TGT_ADDR) begin
                                    state <= StAddrAck;
                                    rw    <= sda_s;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= StWaitStop;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK, the next one ends it.
                    StAddrAck, StWrAck: begin
                        if (scl_fall) begin
                            if (!ack_hold) begin
                                ack_hold <= 1'b1;
                                sda_oe   <= 1'b1;
                            end else begin
                                ack_hold <= 1'b0;
                                sda_oe   <= 1'b0;
                                if (state == StAddrAck && rw) begin
                                    shreg   <= tx_data;
                                    tx_req  <= 1'b1;
                                    sda_oe  <= ~tx_data[7];
                                    bit_cnt <= 3'd0;
                                    state   <= StRead;
                                end else begin
                                    state <= StWrite;
                                end
                            end
                        end
                    end
                    StWrite: begin
                        if (scl_rise) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= shifted;
                                rx_valid <= 1'b1;
                                state    <= StWrAck;
                            end
                        end
                    end
                    // Bit 7 is already on the bus on entry; each fall presents the next bit.
                    StRead: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= StRdAck;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= StWaitStop;
                            end else begin
                                ack_hold <= 1'b1;
                            end
                        end else if (scl_fall && ack_hold) begin
                            ack_hold <= 1'b0;
                            shreg    <= tx_data;
                            tx_req   <= 1'b1;
                            sda_oe   <= ~tx_data[7];
                            state    <= StRead;
                        end
                    end
                    StIdle, StWaitStop: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target acting as a bus controller.
// The controller drives the open-drain line through sda_low; a pullup models
// the bus resistor. Each quarter SCL period is QTR ns (10 system clocks).
module tb_i2c_target;

    localparam int QTR = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    wire        sda;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target #(.TGT_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;

    always @(posedge clk) begin
        if (rx_valid) rx_pulses <= rx_pulses + 1;
        if (tx_req)   tx_pulses <= tx_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks below except bus_start assume scl is low on entry.
    task automatic bus_start();
        sda_low = 1'b0; #QTR;
        scl = 1'b1;     #QTR;
        sda_low = 1'b1; #QTR;
        scl = 1'b0;     #QTR;
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; #QTR;
        scl = 1'b1;     #QTR;
        sda_low = 1'b0; #(2 * QTR);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b; #QTR;
        scl = 1'b1;   #(2 * QTR);
        scl = 1'b0;   #QTR;
    endtask

    // Ninth clock with the line released; returns what the bus shows while scl is high.
    task automatic ack_clock(output logic s);
        sda_low = 1'b0; #QTR;
        scl = 1'b1;     #QTR;
        s = sda;        #QTR;
        scl = 1'b0;     #QTR;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        b = 8'h00;
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #QTR; scl = 1'b1;
            #QTR; b[i] = sda;
            #QTR; scl = 1'b0;
            #QTR;
        end
        sda_low = ~ack_bit; #QTR;
        scl = 1'b1;         #(2 * QTR);
        scl = 1'b0;         #QTR;
        sda_low = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx_base;
        int         tx_base;

        rst = 1'b1; scl = 1'b1; sda_low = 1'b0; tx_data = 8'h00;
        #30;
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset tx_req", tx_req, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sda", sda, 1'b1);
        #20; rst = 1'b0; #(2 * QTR);

        // Plain write of one data byte.
        rx_base = rx_pulses;
        bus_start();
        write_byte(8'hA0, ack);
        check("wr addr ack", ack, 1'b0);
        check("wr busy after match", busy, 1'b1);
        write_byte(8'h3C, ack);
        check("wr data ack", ack, 1'b0);
        check("wr rx_data", rx_data, 8'h3C);
        check("wr rx_valid count", rx_pulses - rx_base, 1);
        bus_stop();
        check("wr busy after stop", busy, 1'b0);
        check("wr sda after stop", sda, 1'b1);

        // Foreign address: no ACK, no activity.
        rx_base = rx_pulses;
        scl = 1'b0; #QTR;
        bus_start();
        write_byte(8'h52, ack);
        check("nomatch ack", ack, 1'b1);
        check("nomatch busy", busy, 1'b0);
        bus_stop();
        check("nomatch rx_valid count", rx_pulses - rx_base, 0);

        // Read two bytes: ACK the first, NACK the second.
        tx_base = tx_pulses;
        tx_data = 8'h96;
        scl = 1'b0; #QTR;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd addr ack", ack, 1'b0);
        check("rd busy", busy, 1'b1);
        check("rd first tx_req", tx_pulses - tx_base, 1);
        tx_data = 8'h0F;
        read_byte(1'b0, rd);
        check("rd byte0", rd, 8'h96);
        check("rd second tx_req", tx_pulses - tx_base, 2);
        read_byte(1'b1, rd);
        check("rd byte1", rd, 8'h0F);
        check("rd no tx_req after nack", tx_pulses - tx_base, 2);
        check("rd sda released after nack", sda, 1'b1);
        bus_stop();
        check("rd busy after stop", busy, 1'b0);

        // Partial write aborted by repeated START into a read.
        rx_base = rx_pulses;
        tx_data = 8'hC3;
        scl = 1'b0; #QTR;
        bus_start();
        write_byte(8'hA0, ack);
        check("rs first addr ack", ack, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        tx_base = tx_pulses;
        bus_start();
        write_byte(8'hA1, ack);
        check("rs second addr ack", ack, 1'b0);
        check("rs tx_req entered read", tx_pulses - tx_base, 1);
        check("rs no rx_valid", rx_pulses - rx_base, 0);
        check("rs rx_data kept", rx_data, 8'h3C);
        read_byte(1'b1, rd);
        check("rs read byte", rd, 8'hC3);
        bus_stop();

        // STOP after five data bits.
        rx_base = rx_pulses;
        scl = 1'b0; #QTR;
        bus_start();
        write_byte(8'hA0, ack);
        check("stop5 addr ack", ack, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        bus_stop();
        check("stop5 busy", busy, 1'b0);
        check("stop5 rx_data kept", rx_data, 8'h3C);
        check("stop5 no rx_valid", rx_pulses - rx_base, 0);
        check("stop5 sda", sda, 1'b1);
        // Without a START the target must ignore a matching address.
        scl = 1'b0; #QTR;
        write_byte(8'hA0, ack);
        check("idle ignores bus", ack, 1'b1);
        bus_stop();

        // Reset while the target holds the address ACK.
        scl = 1'b0; #QTR;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        sda_low = 1'b0; #QTR;
        scl = 1'b1;     #QTR;
        check("rst ack driven", sda, 1'b0);
        rst = 1'b1; #1;
        check("rst sda released", sda, 1'b1);
        check("rst rx_data", rx_data, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst tx_req", tx_req, 1'b0);
        #(2 * QTR - 1);
        rst = 1'b0; #(2 * QTR);

        rx_base = rx_pulses;
        scl = 1'b0; #QTR;
        bus_start();
        write_byte(8'hA0, ack);
        check("post-rst addr ack", ack, 1'b0);
        write_byte(8'h55, ack);
        check("post-rst data ack", ack, 1'b0);
        bus_stop();
        check("post-rst rx_data", rx_data, 8'h55);
        check("post-rst rx_valid count", rx_pulses - rx_base, 1);
        check("post-rst busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
